// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: owner encodings and counter widths shared by the BRAM port arbiter.
package bram_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_R0 = 2'd1, OWN_R1 = 2'd2} owner_e;
  localparam int STAT_WIDTH = 16;
  localparam int CNT_WIDTH  = 16;
endpackage

// File: rtl/bram_arb_stats.sv
// bram_arb_stats: saturating per-requester grant counters (used when BRAM_ARB_STATS_EN is defined).
module bram_arb_stats
  import bram_arb_pkg::*;
(
  input  logic                  Bus2IP_Clk,
  input  logic                  Bus2IP_Resetn,
  input  logic                  stat_clr,
  input  logic [1:0]            inc,
  output logic [STAT_WIDTH-1:0] stat_gnt0,
  output logic [STAT_WIDTH-1:0] stat_gnt1
);
  logic [STAT_WIDTH-1:0] cnt_q [2];
  logic [STAT_WIDTH-1:0] cnt_d [2];
  always_comb begin
    for (int i = 0; i < 2; i++)
      cnt_d[i] = stat_clr ? '0 : (inc[i] && cnt_q[i] != '1) ? cnt_q[i] + 1'b1 : cnt_q[i];
  end
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end
  assign stat_gnt0 = cnt_q[0];
  assign stat_gnt1 = cnt_q[1];
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin, burst-bounded sharing of one BRAM port between two requesters.
// Optional grant statistics ports are added when BRAM_ARB_STATS_EN is defined.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                  Bus2IP_Clk,
  input  logic                  Bus2IP_Resetn,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  input  logic [DATA_WIDTH-1:0] bram_rdata
`ifdef BRAM_ARB_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [STAT_WIDTH-1:0] stat_gnt0,
  output logic [STAT_WIDTH-1:0] stat_gnt1
`endif
);
  localparam logic [CNT_WIDTH-1:0] MB = CNT_WIDTH'(MAX_BURST);
  owner_e               owner_q, owner_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 last_q, last_d;
  logic [1:0]           rvalid_q, rvalid_d;
  logic                 cur, own_req, oth_req;
  assign gnt0       = owner_q == OWN_R0 && req0;
  assign gnt1       = owner_q == OWN_R1 && req1;
  assign bram_en    = gnt0 | gnt1;
  assign bram_we    = bram_en & (gnt1 ? we1 : we0);
  assign bram_addr  = gnt1 ? addr1 : addr0;
  assign bram_wdata = gnt1 ? wdata1 : wdata0;
  assign rvalid_d   = {gnt1 & ~we1, gnt0 & ~we0};
  assign rvalid0    = rvalid_q[0];
  assign rvalid1    = rvalid_q[1];
  assign rdata0     = bram_rdata;
  assign rdata1     = bram_rdata;
  // last_q holds the index of the requester served most recently; it breaks ties from idle
  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    cur     = owner_q == OWN_R1;
    own_req = cur ? req1 : req0;
    oth_req = cur ? req0 : req1;
    cnt_inc = cnt_q == MB ? cnt_q : cnt_q + 1'b1;
    if (owner_q == OWN_NONE) begin
      cnt_d   = '0;
      owner_d = (req0 && req1) ? (last_q ? OWN_R0 : OWN_R1) : req0 ? OWN_R0 : req1 ? OWN_R1 : OWN_NONE;
    end else if (own_req) begin
      cnt_d = cnt_inc;
      if (cnt_inc == MB && oth_req) begin
        owner_d = cur ? OWN_R0 : OWN_R1;
        cnt_d   = '0;
        last_d  = cur;
      end
    end else begin
      owner_d = oth_req ? (cur ? OWN_R0 : OWN_R1) : OWN_NONE;
      cnt_d   = '0;
      last_d  = cur;
    end
  end
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      owner_q  <= OWN_NONE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      rvalid_q <= '0;
    end else begin
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
    end
  end
`ifdef BRAM_ARB_STATS_EN
  bram_arb_stats u_stats (
    .Bus2IP_Clk   (Bus2IP_Clk),
    .Bus2IP_Resetn(Bus2IP_Resetn),
    .stat_clr     (stat_clr),
    .inc          ({gnt1, gnt0}),
    .stat_gnt0    (stat_gnt0),
    .stat_gnt1    (stat_gnt1)
  );
`endif
endmodule
